// File: rtl/pipeline_stall_pkg.sv
// Shared types for the pipeline stall / interrupt-entry controller.
package pipeline_stall_pkg;

  localparam int SRC_DMEM   = 0;
  localparam int SRC_MULDIV = 1;
  localparam int SRC_IMEM   = 2;
  localparam int NUM_SRC    = 3;

  typedef logic [NUM_SRC-1:0] src_vec_t;

  typedef enum logic [1:0] {
    IRQ_IDLE  = 2'd0,
    IRQ_DRAIN = 2'd1,
    IRQ_TAKE  = 2'd2,
    IRQ_COOL  = 2'd3
  } irq_state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_wait_tracker.sv
// Outstanding-wait tracker for one stall source: pending and abandon flags plus
// this source's contribution to the pipeline stall.
module wait_tracker
  import pipeline_stall_pkg::*;
#(
  parameter bit PULSE_REQ = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic ack_i,
  input  logic release_i,
  output logic stall_o
);

  logic pend_q, pend_d;
  logic abandon_q, abandon_d;
  logic eff_req;

  assign eff_req = req_i & ~abandon_q;
  assign stall_o = pend_q | (eff_req & ~ack_i);

  // A pulse source may retire one op and issue the next on the same edge;
  // a level source holds req through its ack cycle, so the ack must win there.
  always_comb begin
    if (PULSE_REQ) begin
      pend_d    = eff_req ? (pend_q | ~ack_i) : (pend_q & ~ack_i);
      abandon_d = 1'b0;
    end else begin
      pend_d    = pend_q ? ~ack_i : (eff_req & ~ack_i);
      abandon_d = abandon_q & req_i;
    end
    if (release_i && stall_o) begin
      pend_d    = 1'b0;
      abandon_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= 1'b0;
      abandon_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      abandon_q <= abandon_d;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline freeze, watchdog release of hung waits, and interrupt-entry sequencing.
// IRQ_IDLE: free | IRQ_DRAIN: wait for stall to clear | IRQ_TAKE: entry strobe | IRQ_COOL: flush
module pipeline_stall_ctrl
  import pipeline_stall_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dmem_req,
  input  logic               dmem_ack,
  input  logic               imem_req,
  input  logic               imem_ack,
  input  logic               muldiv_start,
  input  logic               muldiv_done,
  input  logic               irq_pending,
  output logic               stall_pipl,
  output logic               issue_block,
  output logic               irq_take,
  output logic               bus_timeout,
  output logic [NUM_SRC-1:0] timeout_src
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  src_vec_t         stall_vec;
  logic             any_ack;
  logic             fire;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  irq_state_t       irq_state_q, irq_state_d;
  logic             bus_timeout_q;
  src_vec_t         timeout_src_q;

  wait_tracker #(.PULSE_REQ(1'b0)) u_dmem (
    .clk       (clk),
    .reset     (reset),
    .req_i     (dmem_req),
    .ack_i     (dmem_ack),
    .release_i (fire),
    .stall_o   (stall_vec[SRC_DMEM])
  );

  wait_tracker #(.PULSE_REQ(1'b1)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .req_i     (muldiv_start),
    .ack_i     (muldiv_done),
    .release_i (fire),
    .stall_o   (stall_vec[SRC_MULDIV])
  );

  wait_tracker #(.PULSE_REQ(1'b0)) u_imem (
    .clk       (clk),
    .reset     (reset),
    .req_i     (imem_req),
    .ack_i     (imem_ack),
    .release_i (fire),
    .stall_o   (stall_vec[SRC_IMEM])
  );

  assign stall_pipl = |stall_vec;
  assign any_ack    = dmem_ack | muldiv_done | imem_ack;

  // Any completion shows the bus is alive, so it both resets and vetoes the watchdog.
  assign fire = stall_pipl & ~any_ack & (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    if (!stall_pipl || any_ack || fire) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + CNT_W'(1);
    end
  end

  always_comb begin
    irq_state_d = irq_state_q;
    case (irq_state_q)
      IRQ_IDLE: begin
        if (irq_pending) begin
          irq_state_d = stall_pipl ? IRQ_DRAIN : IRQ_TAKE;
        end
      end
      IRQ_DRAIN: begin
        if (!irq_pending) begin
          irq_state_d = IRQ_IDLE;
        end else if (!stall_pipl) begin
          irq_state_d = IRQ_TAKE;
        end
      end
      IRQ_TAKE: irq_state_d = IRQ_COOL;
      IRQ_COOL: irq_state_d = IRQ_IDLE;
      default:  irq_state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q        <= '0;
      irq_state_q   <= IRQ_IDLE;
      bus_timeout_q <= 1'b0;
      timeout_src_q <= '0;
    end else begin
      wdog_q        <= wdog_d;
      irq_state_q   <= irq_state_d;
      bus_timeout_q <= fire;
      if (fire) begin
        timeout_src_q <= stall_vec;
      end
    end
  end

  assign irq_take    = (irq_state_q == IRQ_TAKE);
  assign issue_block = (irq_state_q != IRQ_IDLE);
  assign bus_timeout = bus_timeout_q;
  assign timeout_src = timeout_src_q;

endmodule
